// File: rtl/spi_slave_if.sv
// SPI slave front end for the single-port RAM: shifts MOSI frames into RX_W-bit
// command words and shifts RAM read data back out on MISO, one bit per clk.
module spi_slave_if #(
  parameter int unsigned RX_W = 10,
  parameter int unsigned TX_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            SS_n,
  input  logic            MOSI,
  output logic            MISO,
  output logic [RX_W-1:0] rx_data,
  output logic            rx_valid,
  input  logic [TX_W-1:0] tx_data,
  input  logic            tx_valid
);

  localparam int unsigned RxCntW = $clog2(RX_W + 1);
  localparam int unsigned TxCntW = $clog2(TX_W + 2);
  localparam logic [RxCntW-1:0] RxLast = RxCntW'(RX_W - 1);
  localparam logic [RxCntW-1:0] RxDone = RxCntW'(RX_W);
  localparam logic [TxCntW-1:0] TxLast = TxCntW'(TX_W);
  localparam logic [TxCntW-1:0] TxDone = TxCntW'(TX_W + 1);

  typedef enum logic [2:0] {
    StIdle,
    StChkCmd,
    StWrite,
    StReadAdd,
    StReadData
  } state_e;

  state_e            state_q;
  logic [RX_W-2:0]   rx_shift_q;
  logic [RX_W-1:0]   rx_data_q;
  logic              rx_valid_q;
  logic [RxCntW-1:0] rx_cnt_q;
  logic              rd_addr_done_q;
  logic [TX_W-1:0]   tx_shift_q;
  logic [TxCntW-1:0] tx_cnt_q;
  logic              miso_q;

  // tx_cnt_q: 0 = waiting for RAM data, 1..TX_W = bit on MISO, TX_W+1 = finished.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      rx_shift_q     <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_cnt_q       <= '0;
      rd_addr_done_q <= 1'b0;
      tx_shift_q     <= '0;
      tx_cnt_q       <= '0;
      miso_q         <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (SS_n) begin
        state_q  <= StIdle;
        rx_cnt_q <= '0;
        tx_cnt_q <= '0;
        miso_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: state_q <= StChkCmd;
          StChkCmd: begin
            if (!MOSI)               state_q <= StWrite;
            else if (rd_addr_done_q) state_q <= StReadData;
            else                     state_q <= StReadAdd;
          end
          StWrite, StReadAdd, StReadData: begin
            if (rx_cnt_q != RxDone) begin
              rx_shift_q <= {rx_shift_q[RX_W-3:0], MOSI};
              rx_cnt_q   <= rx_cnt_q + RxCntW'(1);
              if (rx_cnt_q == RxLast) begin
                rx_data_q  <= {rx_shift_q, MOSI};
                rx_valid_q <= 1'b1;
                if (state_q == StReadAdd)  rd_addr_done_q <= 1'b1;
                if (state_q == StReadData) rd_addr_done_q <= 1'b0;
              end
            end else if (state_q == StReadData) begin
              if (tx_cnt_q == '0) begin
                if (tx_valid) begin
                  miso_q     <= tx_data[TX_W-1];
                  tx_shift_q <= {tx_data[TX_W-2:0], 1'b0};
                  tx_cnt_q   <= TxCntW'(1);
                end
              end else if (tx_cnt_q < TxLast) begin
                miso_q     <= tx_shift_q[TX_W-1];
                tx_shift_q <= tx_shift_q << 1;
                tx_cnt_q   <= tx_cnt_q + TxCntW'(1);
              end else if (tx_cnt_q == TxLast) begin
                miso_q   <= 1'b0;
                tx_cnt_q <= TxDone;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule
